// File: rtl/score_display_if.sv
// ============================================================================
// Module      : score_display_if
// Description : Score value in, multiplexed 7-segment display signals out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface score_display_if #(
    parameter int BW = 7
);
    logic [BW-1:0] value;
    logic [6:0]    seg;
    logic [1:0]    dig_sel;
    logic          busy;
    logic          overflow;

    modport master (output value, input seg, dig_sel, busy, overflow);
    modport slave  (input value, output seg, dig_sel, busy, overflow);
endinterface

`default_nettype wire

// File: rtl/score_display.sv
// ============================================================================
// Module      : score_display
// Description : Binary score -> BCD via sequential double-dabble, driving a
//               two-digit multiplexed common-cathode 7-segment display.
//               Optional macro SCORE_DISPLAY_BLANK_EN blanks a leading zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_display #(
    parameter int BW          = 7,
    parameter int REFRESH_DIV = 1024
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    score_display_if.slave    bus
);

    localparam int ITW = $clog2(BW + 1);
    localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] c_dash = 7'h40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   last_q;
    logic [BW-1:0]   bin_q;
    logic [11:0]     bcd_q;
    logic [ITW-1:0]  iter_q;
    logic [3:0]      tens_q;
    logic [3:0]      units_q;
    logic            ovf_q;
    logic [RW-1:0]   refresh_q;
    logic            sel_q;

    logic [11:0]     bcd_adj;
    logic [3:0]      digit;
    logic [6:0]      seg_val;

    // Nibble-local add-3 correction applied before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < 3; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.value != last_q) begin
                        bin_q   <= bus.value;
                        last_q  <= bus.value;
                        bcd_q   <= '0;
                        iter_q  <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    iter_q         <= iter_q + ITW'(1);
                    if (iter_q == ITW'(BW - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    tens_q  <= bcd_q[7:4];
                    units_q <= bcd_q[3:0];
                    ovf_q   <= (8'(last_q) > 8'd99);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Free-running digit refresh, independent of the converter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            refresh_q <= '0;
            sel_q     <= 1'b0;
        end else if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            sel_q     <= ~sel_q;
        end else begin
            refresh_q <= refresh_q + RW'(1);
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    always_comb begin
        digit   = sel_q ? tens_q : units_q;
        seg_val = ovf_q ? c_dash : seg_of(digit);
`ifdef SCORE_DISPLAY_BLANK_EN
        if (!ovf_q && sel_q && (tens_q == 4'd0)) begin
            seg_val = 7'h00;
        end
`else
`endif
    end

    assign bus.seg      = seg_val;
    assign bus.dig_sel  = sel_q ? 2'b10 : 2'b01;
    assign bus.busy     = (state_q != IDLE);
    assign bus.overflow = ovf_q;

endmodule

`default_nettype wire
